// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared 1-cycle registered ALU; routes result/ZF back with tag.
// Define ALU_ARB_FIXED_PRIO_EN for fixed r0 priority (default build: round-robin).
module alu_arbiter #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_op1,
  input  logic [31:0]      r0_op2,
  input  logic [4:0]       r0_shamt,
  input  logic [3:0]       r0_alusig,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_op1,
  input  logic [31:0]      r1_op2,
  input  logic [4:0]       r1_shamt,
  input  logic [3:0]       r1_alusig,
  input  logic [TAG_W-1:0] r1_tag,
  input  logic             flush,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_signal,
  input  logic [31:0]      alu_result,
  input  logic             alu_zf,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_zf,
  output logic             rsp_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic             rr_ptr;
  logic             gnt0, gnt1, accept, illegal;
  logic [31:0]      sel_op1, sel_op2;
  logic [4:0]       sel_shamt;
  logic [3:0]       sel_sig;
  logic [TAG_W-1:0] sel_tag;
  logic             rsp_valid_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (r0_valid && r1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt0 = 1'b1;
`else
        gnt0 = ~rr_ptr;
        gnt1 = rr_ptr;
`endif
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
    accept    = gnt0 | gnt1;
    sel_op1   = gnt1 ? r1_op1    : r0_op1;
    sel_op2   = gnt1 ? r1_op2    : r0_op2;
    sel_shamt = gnt1 ? r1_shamt  : r0_shamt;
    sel_sig   = gnt1 ? r1_alusig : r0_alusig;
    sel_tag   = gnt1 ? r1_tag    : r0_tag;
    illegal   = accept && (sel_sig > 4'd8);
  end

  assign r0_ready   = gnt0;
  assign r1_ready   = gnt1;
  assign alu_op1    = accept ? sel_op1   : '0;
  assign alu_op2    = accept ? sel_op2   : '0;
  assign alu_shamt  = accept ? sel_shamt : '0;
  // Illegal codes issue as add so the ALU output is always fresh for this response.
  assign alu_signal = (accept && !illegal) ? sel_sig : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_tag     <= '0;
      rsp_err     <= 1'b0;
      rr_ptr      <= 1'b0;
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
    end else begin
      rsp_valid_q <= accept & ~flush;
      if (accept) begin
        rsp_id  <= gnt1;
        rsp_tag <= sel_tag;
        rsp_err <= illegal;
      end
      if (gnt0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (gnt1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      rr_ptr <= 1'b0;
`else
      if (accept && (gnt1 == rr_ptr)) rr_ptr <= ~gnt1;
`endif
    end
  end

  // Reset asserted in the response cycle drops the in-flight response.
  assign rsp_valid  = rsp_valid_q & rst_n;
  assign rsp_result = alu_result;
  assign rsp_zf     = alu_zf;

endmodule
